// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MEM stage: serves 16-bit word and byte
// loads/stores against an internal byte array, with a programmable number of
// wait states. stall freezes the pipeline while an access is in flight.
module data_mem_ctrl #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        byteMode,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] a_lo_reg;
  logic [15:0]   wdata_reg;
  logic          byte_reg;
  logic          write_reg;
  logic [7:0]    mem [DEPTH];

  logic          req;
  logic          req_bad;
  logic [AW-1:0] a_hi;

  assign req     = memRead | memWrite;
  // Both strobes at once, or a word access on an odd address, is rejected.
  assign req_bad = (memRead & memWrite) | (~byteMode & addr[0]);
  // Word addresses are even, so the second byte never crosses the array end;
  // the add still wraps naturally at DEPTH.
  assign a_hi    = a_lo_reg + AW'(1);

  // Pipeline hold: pending request in IDLE or any BUSY cycle; never in reset.
  assign stall = ~rst & (((state == IDLE) & req) | (state == BUSY));

  // Access FSM, memory array and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata     <= 16'h0000;
      done      <= 1'b0;
      err       <= 1'b0;
      a_lo_reg  <= '0;
      wdata_reg <= 16'h0000;
      byte_reg  <= 1'b0;
      write_reg <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (req_bad) begin
              // Rejected: answer immediately, touch neither memory nor rdata.
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              a_lo_reg  <= addr[AW-1:0];
              wdata_reg <= wdata;
              byte_reg  <= byteMode;
              write_reg <= memWrite;
              cnt       <= 4'(WAIT_STATES);
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Last wait state: perform the access on this edge.
            if (write_reg) begin
              if (byte_reg) begin
                mem[a_lo_reg] <= wdata_reg[7:0];
              end else begin
                mem[a_lo_reg] <= wdata_reg[15:8];
                mem[a_hi]     <= wdata_reg[7:0];
              end
            end else begin
              if (byte_reg) begin
                rdata <= {8'h00, mem[a_lo_reg]};
              end else begin
                rdata <= {mem[a_lo_reg], mem[a_hi]};
              end
            end
            state <= RESP;
            done  <= 1'b1;
          end
        end
        RESP: begin
          // Pipeline advances this cycle; new requests are sampled from IDLE.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a byte-array model predicts stall/done/
// err/rdata cycle by cycle, plus literal checks on the documented scenarios.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        byteMode = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        stall;
  logic        done;
  logic        err;

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk      (clk),
    .rst      (rst),
    .memRead  (memRead),
    .memWrite (memWrite),
    .byteMode (byteMode),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0]  mem_m [DEPTH];
  logic [15:0] rdata_m = 16'h0000;
  logic        exp_stall = 1'b0;
  logic        exp_done  = 1'b0;
  logic        exp_err   = 1'b0;
  logic        check_en  = 1'b0;

  int run_len  = 0;
  int last_run = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("stall", {15'd0, stall}, {15'd0, exp_stall});
      chk("done",  {15'd0, done},  {15'd0, exp_done});
      chk("err",   {15'd0, err},   {15'd0, exp_err});
      chk("rdata", rdata, rdata_m);
    end
  end

  // Length of the most recent stall burst.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (stall) begin
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 8'h00;
    rdata_m = 16'h0000;
  endtask

  // One request from IDLE; returns in the IDLE cycle after RESP.
  task automatic access(input logic rd, input logic wr, input logic bm,
                        input logic [15:0] a, input logic [15:0] wd);
    logic valid;
    int   n;
    int   ia;
    valid = !(rd && wr) && (bm || !a[0]);
    n     = valid ? int'(WS) + 2 : 1;
    ia    = int'(a) % int'(DEPTH);
    memRead  = rd;
    memWrite = wr;
    byteMode = bm;
    addr     = a;
    wdata    = wd;
    for (int i = 0; i < n; i++) begin
      exp_stall = 1'b1;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      @(posedge clk); #1;
      // Scramble inputs after acceptance: latched values must be used.
      if (i == 0 && valid) begin
        addr     = ~a;
        wdata    = ~wd;
        byteMode = ~bm;
      end
    end
    // Response cycle: memory effect is visible now.
    if (valid) begin
      if (wr) begin
        if (bm) mem_m[ia] = wd[7:0];
        else begin
          mem_m[ia] = wd[15:8];
          mem_m[(ia + 1) % int'(DEPTH)] = wd[7:0];
        end
      end else begin
        if (bm) rdata_m = {8'h00, mem_m[ia]};
        else    rdata_m = {mem_m[ia], mem_m[(ia + 1) % int'(DEPTH)]};
      end
    end
    memRead   = 1'b0;
    memWrite  = 1'b0;
    exp_stall = 1'b0;
    exp_done  = 1'b1;
    exp_err   = !valid;
    @(posedge clk); #1;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    $display("access rd=%0d wr=%0d byte=%0d addr=%h wdata=%h valid=%0d rdata_model=%h",
             rd, wr, bm, a, wd, valid, rdata_m);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {15'd0, stall}, 16'd0);
    chk("reset_done",  {15'd0, done},  16'd0);
    chk("reset_err",   {15'd0, err},   16'd0);
    chk("reset_rdata", rdata, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;

    access(1, 0, 0, 16'h0000, 16'h0000);
    chk("lw0_after_reset", rdata, 16'h0000);

    access(0, 1, 0, 16'h0010, 16'hBEEF);
    chk("sw_stall_len", 16'(last_run), 16'(WS + 2));
    access(1, 0, 0, 16'h0010, 16'h0000);
    chk("lw_beef", rdata, 16'hBEEF);

    access(0, 1, 1, 16'h0011, 16'h1242);
    access(1, 0, 0, 16'h0010, 16'h0000);
    chk("lw_be42", rdata, 16'hBE42);
    access(1, 0, 1, 16'h0010, 16'h0000);
    chk("lbu_be", rdata, 16'h00BE);
    access(1, 0, 1, 16'h0011, 16'h0000);
    chk("lbu_42", rdata, 16'h0042);

    access(1, 0, 0, 16'h0013, 16'h0000);
    chk("odd_stall_len", 16'(last_run), 16'd1);
    chk("odd_rdata_kept", rdata, 16'h0042);
    access(1, 1, 0, 16'h0010, 16'h7777);
    access(1, 0, 0, 16'h0010, 16'h0000);
    chk("both_mem_kept", rdata, 16'hBE42);

    // Wrap-around, then back-to-back loads
    access(0, 1, 0, 16'h0102, 16'hA5A5);
    access(1, 0, 0, 16'h0002, 16'h0000);
    chk("wrap_a5a5", rdata, 16'hA5A5);
    access(1, 0, 0, 16'h0010, 16'h0000);
    chk("b2b_second", rdata, 16'hBE42);

    // Reset in the middle of a store
    memWrite = 1'b1;
    byteMode = 1'b0;
    addr     = 16'h0020;
    wdata    = 16'h1234;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {15'd0, stall}, 16'd0);
    chk("rst_mid_done",  {15'd0, done},  16'd0);
    chk("rst_mid_rdata", rdata, 16'h0000);
    memWrite = 1'b0;
    model_clear();
    exp_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_en = 1'b1;
    access(1, 0, 0, 16'h0020, 16'h0000);
    chk("aborted_sw", rdata, 16'h0000);
    access(1, 0, 0, 16'h0010, 16'h0000);
    chk("mem_cleared", rdata, 16'h0000);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
